jt51_dac_seq: RTL and testbench

// Serial DAC output sequencer for the JT51 output stage. Accepts stereo 16-bit
// two's-complement sample pairs through a valid/ready handshake. Shares one

---
 rtl/jt51_dac_seq.sv | 153 +++++++++++++++
 tb/tb_jt51_dac_seq.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt51_dac_seq.sv
// jt51_dac_seq: YM3012-style serial DAC sequencer for the JT51 output stage.
// Stereo pairs are converted through one shared lin2exp and shifted out as 13-bit float words.
module jt51_dac_seq #(
  parameter int BITDIV = 2
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        cen,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] left,
  input  logic [15:0] right,
  output logic [15:0] cnv_lin,
  input  logic [9:0]  cnv_man,
  input  logic [2:0]  cnv_exp,
  output logic        so,
  output logic        sh1,
  output logic        sh2,
  output logic        underrun
);

  typedef enum logic [1:0] {IDLE, CONV_L, CONV_R, PEND} state_t;

  localparam logic [3:0] DIVLAST = 4'(BITDIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  divider;
  logic [4:0]  slot;
  logic [4:0]  slot_nxt;
  logic        tick;
  logic        boundary;
  logic        accept;
  logic        load;
  logic [15:0] hold_l;
  logic [15:0] hold_r;
  logic [12:0] nxt_l;
  logic [12:0] nxt_r;
  logic [12:0] cur_l;
  logic [12:0] cur_r;
  logic [12:0] word_l;
  logic [12:0] word_r;
  logic [31:0] frame;
  logic [30:0] shreg;
  logic        armed;

  assign tick     = cen && (divider == DIVLAST);
  assign boundary = tick && (slot == 5'd31);
  assign accept   = in_valid && in_ready;
  assign load     = boundary && (state == PEND);
  assign slot_nxt = slot + 5'd1;

  // Words are {exp, man}; each channel gets three leading zero slots, then LSB-first bits.
  assign word_l = load ? nxt_l : cur_l;
  assign word_r = load ? nxt_r : cur_r;
  assign frame  = {word_r, 3'b000, word_l, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      divider <= 4'd0;
      slot    <= 5'd0;
    end else if (cen) begin
      divider <= tick ? 4'd0 : divider + 4'd1;
      if (tick)
        slot <= slot_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CONV_L;
      CONV_L:  state_nxt = CONV_R;
      CONV_R:  state_nxt = PEND;
      PEND:    if (boundary) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
    cnv_lin  = 16'd0;
    case (state)
      CONV_L:  cnv_lin = hold_l;
      CONV_R:  cnv_lin = hold_r;
      default: cnv_lin = 16'd0;
    endcase
  end

  // The converter is shared: each channel's result is captured during its own conversion clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_l <= 16'd0;
      hold_r <= 16'd0;
      nxt_l  <= 13'd0;
      nxt_r  <= 13'd0;
    end else begin
      if (accept) begin
        hold_l <= left;
        hold_r <= right;
      end
      if (state == CONV_L)
        nxt_l <= {cnv_exp, cnv_man};
      if (state == CONV_R)
        nxt_r <= {cnv_exp, cnv_man};
    end
  end

  // Without a pending pair the frame boundary reloads the previous words, so the frame repeats.
  always_ff @(posedge clk) begin
    if (rst) begin
      so    <= 1'b0;
      sh1   <= 1'b0;
      sh2   <= 1'b0;
      shreg <= 31'd0;
      cur_l <= 13'd0;
      cur_r <= 13'd0;
    end else if (tick) begin
      if (boundary) begin
        so    <= frame[0];
        shreg <= frame[31:1];
        if (load) begin
          cur_l <= nxt_l;
          cur_r <= nxt_r;
        end
      end else begin
        so    <= shreg[0];
        shreg <= {1'b0, shreg[30:1]};
      end
      sh1 <= (slot_nxt == 5'd15);
      sh2 <= (slot_nxt == 5'd31);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
      armed    <= 1'b0;
    end else begin
      underrun <= boundary && !load && armed;
      if (load)
        armed <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jt51_dac_seq.sv
// tb_jt51_dac_seq: randomized directed bench for jt51_dac_seq against a frame-level reference model.
// A second instance with BITDIV=1 and cen tied high checks the one-slot-per-clk pacing.
module tb_jt51_dac_seq;

  localparam int BITDIV = 2;
  localparam int FRAME  = 32 * BITDIV;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        in_valid;
  logic [15:0] left;
  logic [15:0] right;
  logic        in_ready;
  logic [15:0] cnv_lin;
  logic [9:0]  cnv_man;
  logic [2:0]  cnv_exp;
  logic        so;
  logic        sh1;
  logic        sh2;
  logic        underrun;

  logic        cen1;
  logic        in_valid1;
  logic        in_ready1;
  logic [15:0] cnv_lin1;
  logic [9:0]  cnv_man1;
  logic [2:0]  cnv_exp1;
  logic        so1;
  logic        sh11;
  logic        sh21;
  logic        underrun1;

  int vectors;
  int miscompares;
  int cyc;

  // Reference model state: everything is counted in edges and cen pulses since reset.
  int unsigned ecount;
  int unsigned cencnt;
  int unsigned n1;
  bit          have_pend;
  int unsigned pend_edge;
  logic [15:0] pend_l;
  logic [15:0] pend_r;
  logic [12:0] cur_l;
  logic [12:0] cur_r;
  bit          armed;
  bit          exp_under;

  always #5 clk = ~clk;

  jt51_dac_seq #(.BITDIV(BITDIV)) dut (
    .rst(rst), .clk(clk), .cen(cen), .in_valid(in_valid), .in_ready(in_ready),
    .left(left), .right(right), .cnv_lin(cnv_lin), .cnv_man(cnv_man), .cnv_exp(cnv_exp),
    .so(so), .sh1(sh1), .sh2(sh2), .underrun(underrun)
  );

  jt51_dac_seq #(.BITDIV(1)) dut1 (
    .rst(rst), .clk(clk), .cen(cen1), .in_valid(in_valid1), .in_ready(in_ready1),
    .left(left), .right(right), .cnv_lin(cnv_lin1), .cnv_man(cnv_man1), .cnv_exp(cnv_exp1),
    .so(so1), .sh1(sh11), .sh2(sh21), .underrun(underrun1)
  );

  // Floating-point conversion: count redundant sign bits below bit 15 (max 6), exp = 7 - count.
  function automatic logic [12:0] lin2exp(input logic [15:0] lin);
    int n;
    bit run;
    logic [15:0] sh;
    n = 0;
    run = 1'b1;
    for (int i = 14; i >= 9; i--) begin
      if (run && (lin[i] == lin[15])) n++;
      else run = 1'b0;
    end
    sh = lin >> (6 - n);
    return {3'(7 - n), sh[9:0]};
  endfunction

  always_comb begin
    {cnv_exp, cnv_man}   = lin2exp(cnv_lin);
    {cnv_exp1, cnv_man1} = lin2exp(cnv_lin1);
  end

  function automatic logic frameBit(input logic [12:0] wl, input logic [12:0] wr, input int s);
    int c;
    logic [12:0] w;
    c = s % 16;
    w = (s < 16) ? wl : wr;
    if (c < 3) return 1'b0;
    return w[c - 3];
  endfunction

  function automatic logic cenFor(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'(($urandom % 2) == 0);
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  task automatic modelEdge();
    bit tick;
    bit boundary;
    bit ready_pre;
    int slot_pre;
    ecount++;
    if (rst) begin
      cencnt    = 0;
      have_pend = 1'b0;
      armed     = 1'b0;
      cur_l     = 13'd0;
      cur_r     = 13'd0;
      exp_under = 1'b0;
      n1        = 0;
      return;
    end
    n1++;
    tick      = cen && ((cencnt % BITDIV) == BITDIV - 1);
    slot_pre  = (cencnt / BITDIV) % 32;
    boundary  = tick && (slot_pre == 31);
    ready_pre = !have_pend;
    exp_under = 1'b0;
    if (boundary) begin
      if (have_pend && (ecount - pend_edge >= 3)) begin
        cur_l     = lin2exp(pend_l);
        cur_r     = lin2exp(pend_r);
        have_pend = 1'b0;
        armed     = 1'b1;
      end else begin
        exp_under = armed;
      end
    end
    if (cen) cencnt = (cencnt + 1) % FRAME;
    if (in_valid && ready_pre) begin
      have_pend = 1'b1;
      pend_edge = ecount;
      pend_l    = left;
      pend_r    = right;
    end
  endtask

  task automatic checkOutput();
    int s;
    int s1;
    logic [15:0] e_lin;
    s  = (cencnt / BITDIV) % 32;
    s1 = n1 % 32;
    e_lin = 16'd0;
    if (have_pend && (ecount - pend_edge == 0)) e_lin = pend_l;
    if (have_pend && (ecount - pend_edge == 1)) e_lin = pend_r;
    chk("in_ready", 16'(in_ready), 16'(!have_pend));
    chk("cnv_lin", cnv_lin, e_lin);
    chk("so", 16'(so), 16'(frameBit(cur_l, cur_r, s)));
    chk("sh1", 16'(sh1), 16'(s == 15));
    chk("sh2", 16'(sh2), 16'(s == 31));
    chk("underrun", 16'(underrun), 16'(exp_under));
    chk("div1_sh1", 16'(sh11), 16'(s1 == 15));
    chk("div1_sh2", 16'(sh21), 16'(s1 == 31));
    chk("div1_so", 16'(so1), 16'd0);
    chk("div1_underrun", 16'(underrun1), 16'd0);
    chk("div1_in_ready", 16'(in_ready1), 16'd1);
  endtask

  task automatic applyStimulus(input logic v, input logic [15:0] l, input logic [15:0] r,
                               input logic c, input logic rs);
    in_valid = v;
    left     = l;
    right    = r;
    cen      = c;
    rst      = rs;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
    cyc++;
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, 16'd0, cenFor(mode), 1'b0);
  endtask

  task automatic sendPair(input logic [15:0] l, input logic [15:0] r, input int mode);
    int waited;
    waited = 0;
    while (have_pend && waited < 1000) begin
      applyStimulus(1'b0, 16'd0, 16'd0, cenFor(mode), 1'b0);
      waited++;
    end
    if (have_pend) begin
      vectors++;
      miscompares++;
      $error("[TB] FAIL ready_timeout: observed busy expected ready within 1000 clks");
    end
    applyStimulus(1'b1, l, r, cenFor(mode), 1'b0);
  endtask

  initial begin
    logic [15:0] l;
    logic [15:0] r;
    int guard;
    vectors = 0; miscompares = 0; cyc = 0;
    ecount = 0; cencnt = 0; n1 = 0; have_pend = 0; pend_edge = 0;
    pend_l = 0; pend_r = 0; cur_l = 0; cur_r = 0; armed = 0; exp_under = 0;
    cen1 = 1'b1; in_valid1 = 1'b0;
    rst = 1'b1; cen = 1'b0; in_valid = 1'b0; left = 16'd0; right = 16'd0;
    @(negedge clk);

    $display("[TB] reset and three idle frames");
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b1);
    idle(3 * FRAME, 0);

    $display("[TB] directed pairs 4000/0200 and FFFF/0000");
    sendPair(16'h4000, 16'h0200, 0);
    idle(2 * FRAME, 0);
    sendPair(16'hFFFF, 16'h0000, 0);
    idle(2 * FRAME, 0);

    $display("[TB] back-to-back pairs with in_valid held high");
    l = 16'($urandom); r = 16'($urandom);
    for (int i = 0; i < 6 * FRAME; i++) begin
      if (!have_pend) begin
        l = 16'($urandom);
        r = 16'($urandom);
      end
      applyStimulus(1'b1, l, r, 1'b1, 1'b0);
    end

    $display("[TB] single pair then idle, frame repeats with underrun");
    sendPair(16'($urandom), 16'($urandom), 0);
    idle(4 * FRAME, 0);

    $display("[TB] reset at slot 20");
    guard = 0;
    while (((cencnt / BITDIV) % 32 != 20) && guard < 4 * FRAME) begin
      applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b0);
      guard++;
    end
    applyStimulus(1'b0, 16'd0, 16'd0, 1'b1, 1'b1);
    sendPair(16'($urandom), 16'($urandom), 0);
    idle(2 * FRAME, 0);

    $display("[TB] cen every second clk");
    sendPair(16'($urandom), 16'($urandom), 1);
    idle(4 * FRAME, 1);

    $display("[TB] random cen and valid");
    for (int i = 0; i < 30 * FRAME; i++) begin
      applyStimulus(1'(($urandom % 8) == 0), 16'($urandom), 16'($urandom), cenFor(2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
